// File: rtl/ecall_pkg.sv
// Shared definitions for environment-call servicing: FSM states, service
// codes selected by a7, and the ecall instruction encoding used by the decoder.
package ecall_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    OUT_WAIT = 3'd1,
    IN_WAIT  = 3'd2,
    WB       = 3'd3,
    DONE     = 3'd4,
    HALT     = 3'd5
  } ecall_state_e;

  localparam logic [31:0] SYS_PRINT_INT = 32'd1;
  localparam logic [31:0] SYS_READ_INT  = 32'd5;
  localparam logic [31:0] SYS_EXIT      = 32'd10;

  localparam logic [31:0] ECALL_INSN    = 32'h0000_0073;

  // True for the a7 codes that this controller services; others are no-ops.
  function automatic logic is_service(input logic [31:0] code);
    return (code == SYS_PRINT_INT) || (code == SYS_READ_INT) || (code == SYS_EXIT);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchronizer followed by a stability
// counter. The debounced level flips only after DEBOUNCE_CYCLES consecutive
// synchronized samples that disagree with it; btn_rise pulses for one cycle
// on each debounced rising edge.
// Ports:
//   clk, reset  - core clock, async active-high reset
//   btn_raw     - raw asynchronous bouncing button
//   btn_level   - debounced level
//   btn_rise    - one-cycle pulse on debounced rising edge
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stability counter: counts samples disagreeing with the current level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;

endmodule

// File: rtl/ecall_controller.sv
// Environment-call sequencer for the single-cycle RV32I core. Detects an
// ecall, stalls the PC while the service runs, drives the display for
// print-int, writes the switches back into a0 for read-int, and halts on exit.
// Ports:
//   clk, reset              - core clock, async active-high reset
//   ecall_valid             - current instruction is ecall
//   a7, a0                  - service code and argument registers
//   switch_in               - board switches (clk-synchronous)
//   confirm_btn             - raw bouncing confirm button
//   cpu_stall               - combinational PC hold (also gates core regWrite)
//   a0_we, a0_wdata         - x10 write request and data
//   disp_value, disp_valid  - display value and pending-print flag
//   halted                  - program has exited
module ecall_controller
  import ecall_pkg::*;
#(
  parameter int unsigned SW_W            = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ecall_valid,
  input  logic [31:0]     a7,
  input  logic [31:0]     a0,
  input  logic [SW_W-1:0] switch_in,
  input  logic            confirm_btn,
  output logic            cpu_stall,
  output logic            a0_we,
  output logic [31:0]     a0_wdata,
  output logic [31:0]     disp_value,
  output logic            disp_valid,
  output logic            halted
);

  ecall_state_e state_q, state_d;
  logic [31:0]  a0_wdata_q, a0_wdata_d;
  logic [31:0]  disp_value_q, disp_value_d;
  logic         disp_valid_q, disp_valid_d;
  logic         armed_q, armed_d;
  logic         btn_level, btn_rise;
  logic         confirm;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (confirm_btn),
    .btn_level(btn_level),
    .btn_rise (btn_rise)
  );

  // A wait state completes only on a press that began after the button was
  // seen released; a button held across entry never counts.
  assign confirm = btn_rise & armed_q;

  // Next-state and stall decode.
  always_comb begin
    state_d      = state_q;
    a0_wdata_d   = a0_wdata_q;
    disp_value_d = disp_value_q;
    disp_valid_d = disp_valid_q;
    armed_d      = armed_q;
    cpu_stall    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Stall in the detection cycle, otherwise the PC moves past the ecall.
        if (ecall_valid && is_service(a7)) begin
          cpu_stall = 1'b1;
          armed_d   = ~btn_level;
          if (a7 == SYS_PRINT_INT) begin
            state_d      = OUT_WAIT;
            disp_value_d = a0;
            disp_valid_d = 1'b1;
          end else if (a7 == SYS_READ_INT) begin
            state_d = IN_WAIT;
          end else begin
            state_d = HALT;
          end
        end
      end
      OUT_WAIT: begin
        cpu_stall = 1'b1;
        if (!btn_level) armed_d = 1'b1;
        if (confirm) begin
          state_d      = DONE;
          disp_valid_d = 1'b0;
        end
      end
      IN_WAIT: begin
        cpu_stall = 1'b1;
        if (!btn_level) armed_d = 1'b1;
        if (confirm) begin
          state_d    = WB;
          a0_wdata_d = 32'(switch_in);
        end
      end
      WB: begin
        cpu_stall = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      HALT: begin
        cpu_stall = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Reset clears the stall at once even while the ecall is still presented.
    if (reset) cpu_stall = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      a0_wdata_q   <= '0;
      disp_value_q <= '0;
      disp_valid_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      a0_wdata_q   <= a0_wdata_d;
      disp_value_q <= disp_value_d;
      disp_valid_q <= disp_valid_d;
      armed_q      <= armed_d;
    end
  end

  assign a0_we      = (state_q == WB);
  assign halted     = (state_q == HALT);
  assign a0_wdata   = a0_wdata_q;
  assign disp_value = disp_value_q;
  assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_ecall_controller.sv
// Scoreboard bench for ecall_controller with DEBOUNCE_CYCLES=4.
module tb_ecall_controller;

  localparam int unsigned SW_W = 16;
  localparam int unsigned DEB  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            ecall_valid;
  logic [31:0]     a7, a0;
  logic [SW_W-1:0] switch_in;
  logic            confirm_btn;
  logic            cpu_stall, a0_we, disp_valid, halted;
  logic [31:0]     a0_wdata, disp_value;

  ecall_controller #(.SW_W(SW_W), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .reset      (reset),
    .ecall_valid(ecall_valid),
    .a7         (a7),
    .a0         (a0),
    .switch_in  (switch_in),
    .confirm_btn(confirm_btn),
    .cpu_stall  (cpu_stall),
    .a0_we      (a0_we),
    .a0_wdata   (a0_wdata),
    .disp_value (disp_value),
    .disp_valid (disp_valid),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_write;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT writes a0 or raises a print.
  task automatic run_monitor();
    logic disp_prev;
    exp_t e;
    disp_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (a0_we === 1'b1) begin
        if (exp_q.size() == 0 || !exp_q[0].is_write) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_a0_we: got a0_we=1 data %h, expected no write", a0_wdata);
        end else begin
          e = exp_q.pop_front();
          check("a0_wdata", a0_wdata, e.data);
        end
      end
      if (disp_valid === 1'b1 && !disp_prev) begin
        if (exp_q.size() == 0 || exp_q[0].is_write) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_print: got disp_value %h, expected no print", disp_value);
        end else begin
          e = exp_q.pop_front();
          check("disp_value", disp_value, e.data);
        end
      end
      disp_prev = disp_valid;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press the button; when DONE (stall low) is seen, retire the ecall as the PC would.
  task automatic press_service(input int hold, input int budget);
    bit done;
    done = 1'b0;
    confirm_btn = 1'b1;
    for (int i = 1; i <= budget && !(done && i > hold); i++) begin
      @(negedge clk);
      if (i == hold) confirm_btn = 1'b0;
      if (!done && cpu_stall === 1'b0) begin
        done = 1'b1;
        ecall_valid = 1'b0;
        check("done_a0_we", 32'(a0_we), 32'd0);
      end
    end
    confirm_btn = 1'b0;
    check("done_reached", 32'(done), 32'd1);
  endtask

  task automatic issue(input logic [31:0] code, input logic [31:0] arg);
    a7 = code;
    a0 = arg;
    ecall_valid = 1'b1;
    #1;
  endtask

  initial begin
    reset = 1'b1; ecall_valid = 1'b0; a7 = '0; a0 = '0;
    switch_in = '0; confirm_btn = 1'b0;
    fork run_monitor(); join_none

    // Reset state.
    cyc(1);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_a0_we", 32'(a0_we), 32'd0);
    check("rst_a0_wdata", a0_wdata, 32'd0);
    check("rst_disp_value", disp_value, 32'd0);
    check("rst_disp_valid", 32'(disp_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    reset = 1'b0;
    cyc(2);

    // Read int: switches 00A5 land in a0.
    switch_in = 16'h00A5;
    issue(32'd5, 32'h0);
    check("read_stall_detect", 32'(cpu_stall), 32'd1);
    exp_q.push_back('{is_write: 1'b1, data: 32'h0000_00A5});
    cyc(1);
    press_service(8, 40);
    cyc(1);
    check("read_idle_stall", 32'(cpu_stall), 32'd0);
    cyc(8);

    // Print int: negative value shown, no a0 write.
    issue(32'd1, 32'hFFFF_FFF9);
    check("print_stall_detect", 32'(cpu_stall), 32'd1);
    exp_q.push_back('{is_write: 1'b0, data: 32'hFFFF_FFF9});
    cyc(1);
    check("print_disp_valid", 32'(disp_valid), 32'd1);
    check("print_stall_hold", 32'(cpu_stall), 32'd1);
    press_service(8, 40);
    check("print_disp_cleared", 32'(disp_valid), 32'd0);
    check("print_disp_held", disp_value, 32'hFFFF_FFF9);
    cyc(8);

    // Bounce: fast toggling never completes; switches sampled only on the real press.
    switch_in = 16'h1234;
    issue(32'd5, 32'h0);
    cyc(1);
    for (int i = 0; i < 10; i++) begin
      confirm_btn = ~confirm_btn;
      cyc(1);
    end
    confirm_btn = 1'b0;
    cyc(10);
    check("bounce_still_wait", 32'(cpu_stall), 32'd1);
    switch_in = 16'h8001;
    exp_q.push_back('{is_write: 1'b1, data: 32'h0000_8001});
    press_service(8, 40);
    cyc(8);

    // Held button: a press held across entry does not complete the read.
    confirm_btn = 1'b1;
    cyc(10);
    switch_in = 16'h00FF;
    issue(32'd5, 32'h0);
    cyc(10);
    check("held_no_complete", 32'(cpu_stall), 32'd1);
    confirm_btn = 1'b0;
    cyc(8);
    check("held_after_release", 32'(cpu_stall), 32'd1);
    exp_q.push_back('{is_write: 1'b1, data: 32'h0000_00FF});
    press_service(8, 40);
    cyc(8);

    // Unknown service: no stall, no side effect.
    issue(32'd7, 32'h1111_1111);
    check("unknown_stall_same_cycle", 32'(cpu_stall), 32'd0);
    cyc(1);
    check("unknown_stall_next", 32'(cpu_stall), 32'd0);
    check("unknown_disp_valid", 32'(disp_valid), 32'd0);
    check("unknown_halted", 32'(halted), 32'd0);
    ecall_valid = 1'b0;
    cyc(2);

    // Reset asserted between edges in IN_WAIT, then a fresh ecall completes.
    switch_in = 16'hBEEF;
    issue(32'd5, 32'h0);
    cyc(3);
    #2 reset = 1'b1;
    #1;
    check("arst_stall", 32'(cpu_stall), 32'd0);
    check("arst_a0_we", 32'(a0_we), 32'd0);
    check("arst_a0_wdata", a0_wdata, 32'd0);
    check("arst_disp_value", disp_value, 32'd0);
    check("arst_disp_valid", 32'(disp_valid), 32'd0);
    check("arst_halted", 32'(halted), 32'd0);
    cyc(2);
    reset = 1'b0;
    #1;
    check("arst_reaccept_stall", 32'(cpu_stall), 32'd1);
    exp_q.push_back('{is_write: 1'b1, data: 32'h0000_BEEF});
    cyc(1);
    press_service(8, 40);
    cyc(8);

    // Exit: terminal halt, presses ignored.
    issue(32'd10, 32'h0);
    check("exit_stall_detect", 32'(cpu_stall), 32'd1);
    cyc(1);
    ecall_valid = 1'b0;
    check("exit_halted", 32'(halted), 32'd1);
    confirm_btn = 1'b1;
    cyc(8);
    confirm_btn = 1'b0;
    cyc(10);
    check("exit_halted_hold", 32'(halted), 32'd1);
    check("exit_stall_hold", 32'(cpu_stall), 32'd1);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
